raystore_rd_pipe: RTL and testbench
===================================

Name: raystore_rd_pipe

Overview:
- Downstream stage of raystore_arb.
- Takes the up-to-two grants issued each cycle, drives the two read ports of the dual-port ray store RAM, and tracks each read's requester tag through the fixed RAM latency.
- Steers returned ray data into one small per-requester output FIFO.
- Generates the per-requester pipe_stall back to the arbiter, using credits so that no FIFO can overflow.

Parameters:
- N, 4, number of requesters; power of two, 2..8.
- ADDR_W, 9, ray store address (rayID) width.
- RAY_W, 192, ray record width.
- MEM_LAT, 2, fixed RAM read latency in cycles, 1..4.
- FIFO_D, 4, per-requester output FIFO depth; must be >= 2.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-low reset.
- us_raddr  in  N*ADDR_W  read address of each requester; slice i belongs to requester i.
- pipe_valid  in  N  requesters granted by raystore_arb this cycle; at most 2 bits set.
- mux_sel0  in  $clog2(N)  requester index served on port 0.
- mux_sel1  in  $clog2(N)  requester index served on port 1.
- pipe_stall  out  N  requester i must not be granted this cycle.
- rd_en0, rd_en1  out  1  RAM port read enables.
- rd_addr0, rd_addr1  out  ADDR_W  RAM port addresses.
- rd_data0, rd_data1  in  RAY_W  RAM read data; valid MEM_LAT cycles after rd_en.
- ds_valid  out  N  output FIFO i is non-empty.
- ds_data  out  N*RAY_W  head entry of FIFO i.
- ds_stall  in  N  downstream consumer i is not accepting.
- ovf_err  out  1  sticky protocol-error flag.

Behaviour:
- Grant decode (combinational):
  - g0 = pipe_valid[mux_sel0].
  - g1 = pipe_valid[mux_sel1] & (mux_sel1 != mux_sel0).
  - A grant whose requester has pipe_stall set is dropped: no read is issued and ovf_err sets.
- Read issue (combinational):
  - rd_en0 = accepted g0; rd_addr0 = us_raddr slice mux_sel0.
  - Port 1 is identical using mux_sel1.
  - Addresses are driven regardless of enables.
- Tag pipeline:
  - Per port, a MEM_LAT-stage shift register of {v, sel}, loaded from the accepted grant.
  - When stage MEM_LAT has v=1, rd_data of that port is written into FIFO[sel] in the same cycle.
  - Both ports returning to the same FIFO cannot occur, because sel0 != sel1 at issue.
- Credit counter res[i], width clog2(FIFO_D)+1, counts FIFO occupancy plus in-flight reads:
  - Increments on an accepted grant to i.
  - Decrements on a pop from i.
  - Unchanged when both happen in the same cycle.
  - pipe_stall[i] = (res[i] == FIFO_D), decoded from registers only, with no combinational path from any input.
  - res[i] never exceeds FIFO_D.
- Output FIFOs:
  - ds_valid[i] = FIFO i non-empty; ds_data slice i = head entry.
  - Pop occurs when ds_valid[i] & ~ds_stall[i].
  - Write and pop on the same FIFO in the same cycle are both performed; occupancy is unchanged.
  - Write while full cannot occur, because credits prevent it.
  - Read and write pointers wrap modulo FIFO_D.
- Latency: grant at cycle t → data written at the end of cycle t+MEM_LAT → ds_valid high from cycle t+MEM_LAT+1.
- FIFOs are first-in first-out per requester; there is no cross-requester ordering.
- ovf_err: set on a dropped grant, and also when more than 2 pipe_valid bits are set (the extra grants are ignored); cleared only by reset.
- Reset (rst=0), asynchronous and valid mid-operation:
  - Tag shift registers cleared; in-flight reads are discarded and their late rd_data is ignored.
  - FIFO pointers and res[] set to 0.
  - Outputs: ds_valid=0, pipe_stall=0, rd_en0=rd_en1=0, ovf_err=0.
  - ds_data is don't-care.

Decomposition:
- raystore_pkg holds:
  - Ray record typedef ray_t (RAY_W bits).
  - rayID typedef.
  - Tag struct {logic v; logic [$clog2(N)-1:0] sel;}.
  - Default constants for N, MEM_LAT and FIFO_D.
- Sub-module raystore_ofifo: a single-write, single-read FIFO of depth FIFO_D with a res counter and stall output; instantiated N times in a generate loop.

Test Plan:
- Single grant: pipe_valid=0001, mux_sel0=0, us_raddr[0]=0x05; RAM model returns 0xA5 → rd_en0=1 and rd_addr0=0x05 at cycle t, ds_valid[0]=1 with ds_data[0]=0xA5 at t+3 (MEM_LAT=2), all other ds_valid stay 0.
- Dual grant: pipe_valid=1010, mux_sel0=1, mux_sel1=3 → both ports fire in the same cycle, ds_valid=1010 three cycles later, each slice carries its own address's data.
- Credit stall: hold ds_stall[2]=1 and grant requester 2 on consecutive cycles → pipe_stall[2] rises the cycle after the 4th grant, all 4 entries retained in order; release ds_stall → one pop per cycle, pipe_stall[2] drops the cycle after the first pop.
- Protocol error: grant requester 2 while pipe_stall[2]=1 → no rd_en, res[2] unchanged, ovf_err=1 and stays 1 until reset.
- Simultaneous grant and pop on requester 0 with res[0]=2 → res[0] stays 2, pipe_stall[0]=0.
- Mid-flight reset: assert rst=0 one cycle after a grant → immediately ds_valid=0, pipe_stall=0, ovf_err=0; after release, the late rd_data from that grant never appears on ds_data.

Source files
------------

// File: rtl/raystore_pkg.sv
// raystore_pkg: shared types and default sizes for the ray store read pipe
package raystore_pkg;
  localparam int N_DEF = 4;
  localparam int ADDR_W_DEF = 9;
  localparam int RAY_W_DEF = 192;
  localparam int MEM_LAT_DEF = 2;
  localparam int FIFO_D_DEF = 4;
  localparam int SEL_W = 3;
  typedef logic [RAY_W_DEF-1:0] ray_t;
  typedef logic [ADDR_W_DEF-1:0] ray_id_t;
  typedef struct packed {
    logic v;
    logic [SEL_W-1:0] sel;
  } tag_t;
endpackage

// File: rtl/raystore_ofifo.sv
// raystore_ofifo: per-requester output FIFO with read-credit tracking
module raystore_ofifo import raystore_pkg::*; #(
  parameter int FIFO_D = FIFO_D_DEF,
  parameter int RAY_W = RAY_W_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic grant,
  input  logic wr_en,
  input  logic [RAY_W-1:0] wr_data,
  input  logic ds_stall,
  output logic ds_valid,
  output logic [RAY_W-1:0] ds_data,
  output logic stall
);
  localparam int PW = $clog2(FIFO_D);
  localparam int CW = $clog2(FIFO_D) + 1;
  logic [RAY_W-1:0] mem [FIFO_D];
  logic [PW-1:0] wptr, rptr;
  logic [CW-1:0] cnt, res;
  logic pop;
  assign ds_valid = cnt != '0;
  assign ds_data = mem[rptr];
  assign pop = ds_valid & ~ds_stall;
  assign stall = res == CW'(FIFO_D);
  // pointers wrap modulo depth; res counts stored entries plus reads still in flight
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wptr <= '0;
      rptr <= '0;
      cnt <= '0;
      res <= '0;
    end else begin
      if (wr_en) wptr <= wptr == PW'(FIFO_D - 1) ? '0 : wptr + 1'b1;
      if (pop) rptr <= rptr == PW'(FIFO_D - 1) ? '0 : rptr + 1'b1;
      cnt <= cnt + CW'(wr_en) - CW'(pop);
      res <= res + CW'(grant) - CW'(pop);
    end
  // storage needs no reset, only the pointers define validity
  always_ff @(posedge clk)
    if (wr_en) mem[wptr] <= wr_data;
endmodule

// File: rtl/raystore_rd_pipe.sv
// raystore_rd_pipe: issues arbiter grants to the dual-port ray store and steers returns into per-requester FIFOs
module raystore_rd_pipe import raystore_pkg::*; #(
  parameter int N = N_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int RAY_W = RAY_W_DEF,
  parameter int MEM_LAT = MEM_LAT_DEF,
  parameter int FIFO_D = FIFO_D_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic [N*ADDR_W-1:0] us_raddr,
  input  logic [N-1:0] pipe_valid,
  input  logic [$clog2(N)-1:0] mux_sel0,
  input  logic [$clog2(N)-1:0] mux_sel1,
  output logic [N-1:0] pipe_stall,
  output logic rd_en0,
  output logic rd_en1,
  output logic [ADDR_W-1:0] rd_addr0,
  output logic [ADDR_W-1:0] rd_addr1,
  input  logic [RAY_W-1:0] rd_data0,
  input  logic [RAY_W-1:0] rd_data1,
  output logic [N-1:0] ds_valid,
  output logic [N*RAY_W-1:0] ds_data,
  input  logic [N-1:0] ds_stall,
  output logic ovf_err
);
  localparam int SW = $clog2(N);
  logic g0, g1, acc0, acc1, err;
  tag_t tp0 [MEM_LAT];
  tag_t tp1 [MEM_LAT];
  tag_t ret0, ret1;
  // grant decode; a grant to a stalled requester is dropped and flagged, nothing issues while in reset
  always_comb begin
    g0 = pipe_valid[mux_sel0];
    g1 = pipe_valid[mux_sel1] & (mux_sel1 != mux_sel0);
    acc0 = g0 & ~pipe_stall[mux_sel0] & rst;
    acc1 = g1 & ~pipe_stall[mux_sel1] & rst;
    err = (g0 & pipe_stall[mux_sel0]) | (g1 & pipe_stall[mux_sel1]) | ($countones(pipe_valid) > 2);
  end
  assign rd_en0 = acc0;
  assign rd_en1 = acc1;
  assign rd_addr0 = us_raddr[mux_sel0*ADDR_W +: ADDR_W];
  assign rd_addr1 = us_raddr[mux_sel1*ADDR_W +: ADDR_W];
  assign ret0 = tp0[MEM_LAT-1];
  assign ret1 = tp1[MEM_LAT-1];
  // tag shift registers carry each read's requester through the RAM latency
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      for (int k = 0; k < MEM_LAT; k++) begin
        tp0[k] <= '0;
        tp1[k] <= '0;
      end
    end else begin
      tp0[0] <= {acc0, SEL_W'(mux_sel0)};
      tp1[0] <= {acc1, SEL_W'(mux_sel1)};
      for (int k = 1; k < MEM_LAT; k++) begin
        tp0[k] <= tp0[k-1];
        tp1[k] <= tp1[k-1];
      end
    end
  // sticky protocol error, only reset clears it
  always_ff @(posedge clk or negedge rst)
    if (!rst) ovf_err <= 1'b0;
    else if (err) ovf_err <= 1'b1;
  for (genvar i = 0; i < N; i++) begin : g_fifo
    logic hit0, hit1;
    assign hit0 = ret0.v & (ret0.sel == SEL_W'(i));
    assign hit1 = ret1.v & (ret1.sel == SEL_W'(i));
    raystore_ofifo #(.FIFO_D(FIFO_D), .RAY_W(RAY_W)) u_fifo (
      .clk(clk),
      .rst(rst),
      .grant((acc0 & (mux_sel0 == SW'(i))) | (acc1 & (mux_sel1 == SW'(i)))),
      .wr_en(hit0 | hit1),
      .wr_data(hit0 ? rd_data0 : rd_data1),
      .ds_stall(ds_stall[i]),
      .ds_valid(ds_valid[i]),
      .ds_data(ds_data[i*RAY_W +: RAY_W]),
      .stall(pipe_stall[i])
    );
  end
endmodule

// File: tb/tb_raystore_rd_pipe.sv
// tb_raystore_rd_pipe: randomized and directed checks of raystore_rd_pipe against a queue-based model
module tb_raystore_rd_pipe;
  import raystore_pkg::*;
  localparam int N = 4;
  localparam int AW = ADDR_W_DEF;
  localparam int RW = RAY_W_DEF;
  localparam int LAT = 2;
  localparam int D = 4;
  localparam int RAW = N * AW;
  logic clk = 1'b0;
  logic rst;
  logic [RAW-1:0] us_raddr;
  logic [N-1:0] pipe_valid, pipe_stall, ds_valid, ds_stall;
  logic [1:0] mux_sel0, mux_sel1;
  logic rd_en0, rd_en1, ovf_err;
  logic [AW-1:0] rd_addr0, rd_addr1;
  ray_t rd_data0, rd_data1;
  logic [N*RW-1:0] ds_data;

  raystore_rd_pipe #(.N(N), .ADDR_W(AW), .RAY_W(RW), .MEM_LAT(LAT), .FIFO_D(D)) dut (
    .clk(clk), .rst(rst), .us_raddr(us_raddr), .pipe_valid(pipe_valid),
    .mux_sel0(mux_sel0), .mux_sel1(mux_sel1), .pipe_stall(pipe_stall),
    .rd_en0(rd_en0), .rd_en1(rd_en1), .rd_addr0(rd_addr0), .rd_addr1(rd_addr1),
    .rd_data0(rd_data0), .rd_data1(rd_data1), .ds_valid(ds_valid), .ds_data(ds_data),
    .ds_stall(ds_stall), .ovf_err(ovf_err)
  );

  always #5 clk = ~clk;

  function automatic ray_t ram(input logic [AW-1:0] a);
    ray_t r;
    for (int k = 0; k < RW / 16; k++) r[k*16 +: 16] = {7'(k), a} ^ 16'hA500;
    return r;
  endfunction

  logic [AW-1:0] ad0 [LAT];
  logic [AW-1:0] ad1 [LAT];
  always @(posedge clk) begin
    ad0[0] <= rd_addr0;
    ad1[0] <= rd_addr1;
    for (int k = 1; k < LAT; k++) begin
      ad0[k] <= ad0[k-1];
      ad1[k] <= ad1[k-1];
    end
  end
  assign rd_data0 = ram(ad0[LAT-1]);
  assign rd_data1 = ram(ad1[LAT-1]);

  typedef struct {
    int due;
    int req;
    ray_t d;
  } pend_t;
  ray_t mq [N][$];
  pend_t pend [$];
  int infl [N];
  bit movf;
  int cyc = 0;
  int nchk = 0;
  int npass = 0;

  task automatic check(input string tag, input logic [RW-1:0] got, input logic [RW-1:0] exp);
    nchk++;
    if (got === exp) npass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic bit stl(input int i);
    return mq[i].size() + infl[i] >= D;
  endfunction

  function automatic logic [RAW-1:0] rnd_ra();
    return RAW'({$urandom(), $urandom()});
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      mq[i].delete();
      infl[i] = 0;
    end
    pend.delete();
    movf = 1'b0;
  endtask

  task automatic check_outs();
    for (int i = 0; i < N; i++) begin
      check($sformatf("pipe_stall[%0d]", i), RW'(pipe_stall[i]), RW'(stl(i)));
      check($sformatf("ds_valid[%0d]", i), RW'(ds_valid[i]), RW'(mq[i].size() != 0));
      if (mq[i].size() != 0) check($sformatf("ds_data[%0d]", i), ds_data[i*RW +: RW], mq[i][0]);
    end
    check("ovf_err", RW'(ovf_err), RW'(movf));
  endtask

  task automatic step(input logic [N-1:0] pv, input int s0, input int s1, input logic [N-1:0] dss, input logic [RAW-1:0] ra);
    bit g0, g1, a0, a1;
    pend_t p;
    check_outs();
    pipe_valid = pv;
    mux_sel0 = 2'(s0);
    mux_sel1 = 2'(s1);
    ds_stall = dss;
    us_raddr = ra;
    #1;
    g0 = pv[s0];
    g1 = pv[s1] && s1 != s0;
    a0 = g0 && !stl(s0);
    a1 = g1 && !stl(s1);
    if ((g0 && !a0) || (g1 && !a1) || $countones(pv) > 2) movf = 1'b1;
    check("rd_en0", RW'(rd_en0), RW'(a0));
    check("rd_en1", RW'(rd_en1), RW'(a1));
    check("rd_addr0", RW'(rd_addr0), RW'(ra[s0*AW +: AW]));
    check("rd_addr1", RW'(rd_addr1), RW'(ra[s1*AW +: AW]));
    for (int i = 0; i < N; i++)
      if (mq[i].size() != 0 && !dss[i]) void'(mq[i].pop_front());
    while (pend.size() != 0 && pend[0].due == cyc) begin
      p = pend.pop_front();
      mq[p.req].push_back(p.d);
      infl[p.req]--;
    end
    if (a0) begin
      p.due = cyc + LAT; p.req = s0; p.d = ram(ra[s0*AW +: AW]);
      pend.push_back(p);
      infl[s0]++;
    end
    if (a1) begin
      p.due = cyc + LAT; p.req = s1; p.d = ram(ra[s1*AW +: AW]);
      pend.push_back(p);
      infl[s1]++;
    end
    cyc++;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0;
    pipe_valid = '1;
    mux_sel0 = 2'd0;
    mux_sel1 = 2'd1;
    ds_stall = '0;
    us_raddr = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check("reset rd_en0", RW'(rd_en0), '0);
    check("reset rd_en1", RW'(rd_en1), '0);
    check_outs();
    pipe_valid = '0;
    rst = 1'b1;
    step(4'b0001, 0, 1, '0, RAW'(9'h005));
    repeat (4) step('0, 0, 1, '0, rnd_ra());
    step(4'b1010, 1, 3, '0, rnd_ra());
    repeat (4) step('0, 0, 1, '0, rnd_ra());
    for (int n = 0; n < 600; n++) begin
      int a, b, k;
      logic [N-1:0] pv, dss;
      a = $urandom_range(0, N - 1);
      b = $urandom_range(0, N - 1);
      k = $urandom_range(0, 2);
      pv = '0;
      if (k >= 1 && !stl(a)) pv[a] = 1'b1;
      if (k == 2 && b != a && !stl(b)) pv[b] = 1'b1;
      dss = (n % 100 < 50) ? (4'($urandom) | 4'($urandom)) : (4'($urandom) & 4'($urandom));
      if ($urandom_range(0, 1) == 1) step(pv, a, b, dss, rnd_ra());
      else step(pv, b, a, dss, rnd_ra());
    end
    repeat (8) step('0, 0, 1, '0, rnd_ra());
    repeat (2) step(4'b0001, 0, 1, 4'b0001, rnd_ra());
    repeat (3) step('0, 0, 1, 4'b0001, rnd_ra());
    step(4'b0001, 0, 1, '0, rnd_ra());
    repeat (4) step('0, 0, 1, '0, rnd_ra());
    repeat (4) step(4'b0100, 2, 0, 4'b0100, rnd_ra());
    repeat (3) step('0, 0, 1, 4'b0100, rnd_ra());
    step(4'b0100, 2, 0, 4'b0100, rnd_ra());
    step(4'b0100, 0, 2, 4'b0100, rnd_ra());
    repeat (8) step('0, 0, 1, '0, rnd_ra());
    step(4'b0010, 1, 0, 4'b1111, rnd_ra());
    rst = 1'b0;
    #1;
    check("midreset ds_valid", RW'(ds_valid), '0);
    check("midreset pipe_stall", RW'(pipe_stall), '0);
    check("midreset ovf_err", RW'(ovf_err), '0);
    check("midreset rd_en0", RW'(rd_en0), '0);
    model_reset();
    @(negedge clk);
    pipe_valid = '0;
    rst = 1'b1;
    repeat (6) step('0, 0, 1, '0, rnd_ra());
    step(4'b0111, 0, 1, '0, rnd_ra());
    repeat (5) step('0, 0, 1, '0, rnd_ra());
    check_outs();
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end
endmodule
